seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
- Serial bit-pattern transmitter. It is the drive-side counterpart of the serial sequence detector: it emits a programmable PAT_W-bit pattern MSB-first on a 1-bit line, one bit per clock.
- The pattern can be repeated N times, with optional idle gap cycles between repetitions.
- Used as on-chip stimulus for detector blocks, and as the transmit end of simple serial pattern links.

Parameters:
- PAT_W, 4: pattern width in bits; one repetition lasts PAT_W cycles.
- CNT_W, 4: width of the repeat count; maximum repetitions is 2^CNT_W-1.
- GAP, 0: idle cycles inserted between consecutive repetitions. 0 means back-to-back.
- IDLE_BIT, 0: value driven on x whenever no pattern bit is being sent.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- start  in  1  request; sampled only in IDLE.
- pattern  in  PAT_W  pattern to send; latched on accepted start.
- repeat_n  in  CNT_W  number of repetitions; latched on accepted start.
- abort  in  1  terminates the current transfer.
- x  out  1  serial data, MSB of pattern first.
- x_valid  out  1  high exactly on cycles where x carries a pattern bit.
- busy  out  1  high in SEND, GAP and DONE.
- done  out  1  one-cycle pulse at normal completion.
- rep_left  out  CNT_W  repetitions not yet started, including none for the current one.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; x=IDLE_BIT; x_valid=0; busy=0; done=0; rep_left=0; shift register and counters cleared.
  - Applies mid-transfer with no completion pulse.
- All outputs are registered.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 and abort=0 latches pattern into the shift register and repeat_n into the repeat counter.
  - If repeat_n=0: next state DONE, and no bit is sent.
  - Otherwise: next state SEND, with rep_left=repeat_n-1.
  - start with abort=1 in the same cycle is ignored.
- SEND:
  - Latency: the first bit appears on x, with x_valid=1, the cycle after start is sampled.
  - Each cycle drives the shift-register MSB on x, shifts left by one, and increments the bit counter (0..PAT_W-1).
  - After bit PAT_W-1:
    - If rep_left=0: next state DONE.
    - Else if GAP>0: next state GAP.
    - Else (GAP=0): reload pattern, decrement rep_left, and stay in SEND. The next repetition's MSB follows with no bubble.
- GAP:
  - Lasts exactly GAP cycles; x=IDLE_BIT, x_valid=0.
  - On exit: reload the latched pattern, decrement rep_left, next state SEND.
- DONE:
  - Lasts one cycle with done=1, x_valid=0, x=IDLE_BIT, busy=1; next state IDLE.
  - busy is low from the following cycle, so a new start can be accepted 2 cycles after the last bit.
- start while busy=1 is ignored. A new pattern or repeat_n has no effect on a transfer in progress.
- abort=1 in SEND, GAP or DONE:
  - Next cycle state=IDLE, x=IDLE_BIT, x_valid=0, busy=0, rep_left=0.
  - done is not asserted; a done pulse already scheduled in that same cycle is suppressed.
- abort in IDLE has no effect other than blocking start.
- Total transfer length for N>0: N*PAT_W + (N-1)*GAP cycles of SEND/GAP, then 1 DONE cycle.
- Counter widths:
  - Bit counter is sized to hold PAT_W-1.
  - Gap counter is sized to hold GAP; it is omitted when GAP=0.
  - No wrap-around is possible because rep_left only decrements from the latched value.

Test Plan:
- Default params; pattern=4'b1101, repeat_n=3, start pulsed at cycle 0 → x_valid=1 for cycles 1–12 with x=1,1,0,1 repeated ×3; done=1 at cycle 13 only; busy=0 at cycle 14.
- GAP=2, IDLE_BIT=0; pattern=4'b0110, repeat_n=2 → x=0110, then 2 cycles x=0 with x_valid=0, then 0110; done at cycle 11.
- repeat_n=0 with start → x_valid never asserted; done=1 on cycle 1; busy=1 on cycle 1 only.
- Transfer of 1101 ×3; start with pattern=4'b0000 at cycle 5 → ignored, output sequence unchanged; same for start asserted in the DONE cycle.
- abort at cycle 6 of 1101 ×3 → cycle 7: x_valid=0, busy=0, rep_left=0, done never pulses; a new start at cycle 8 sends its first bit at cycle 9.
- reset driven low asynchronously between clock edges mid-SEND → outputs go to reset values immediately without a clock edge. After release, start is accepted on the first clock edge.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial bit-pattern transmitter.
// Sends a latched PAT_W-bit pattern MSB-first, one bit per clock, repeated
// repeat_n times with GAP idle cycles between repetitions. All outputs are
// registered; the first bit appears the cycle after start is accepted.
module seq_pattern_gen #(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 4,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] rep_left
);

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   shift_q, shift_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               gap_last_s;

    // Idle-gap counter exists only when repetitions are separated by a gap.
    generate
        if (GAP > 0) begin : g_gap
            localparam int GAP_W = $clog2(GAP + 1);
            localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
            logic [GAP_W-1:0] gap_cnt_q;

            // Count cycles spent in GAP; cleared whenever not mid-gap.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    gap_cnt_q <= '0;
                end else if (state_q == S_GAP && !gap_last_s && !abort) begin
                    gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                end else begin
                    gap_cnt_q <= '0;
                end
            end

            assign gap_last_s = (gap_cnt_q == GAP_LAST);
        end else begin : g_nogap
            assign gap_last_s = 1'b1;
        end
    endgenerate

    // Next-state and next-output decode; outputs describe the coming cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        pat_d     = pat_q;
        rep_d     = rep_q;
        bit_cnt_d = bit_cnt_q;
        x_d       = IDLE_BIT;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    pat_d     = pattern;
                    shift_d   = pattern << 1;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    if (repeat_n == '0) begin
                        state_d = S_DONE;
                        rep_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_SEND;
                        rep_d     = repeat_n - CNT_W'(1);
                        x_d       = pattern[PAT_W-1];
                        x_valid_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                busy_d = 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    if (rep_q == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (GAP > 0) begin
                        state_d = S_GAP;
                    end else begin
                        // Back-to-back: next repetition's MSB with no bubble.
                        state_d   = S_SEND;
                        shift_d   = pat_q << 1;
                        bit_cnt_d = '0;
                        rep_d     = rep_q - CNT_W'(1);
                        x_d       = pat_q[PAT_W-1];
                        x_valid_d = 1'b1;
                    end
                end else begin
                    x_d       = shift_q[PAT_W-1];
                    x_valid_d = 1'b1;
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (gap_last_s) begin
                    state_d   = S_SEND;
                    shift_d   = pat_q << 1;
                    bit_cnt_d = '0;
                    rep_d     = rep_q - CNT_W'(1);
                    x_d       = pat_q[PAT_W-1];
                    x_valid_d = 1'b1;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rep_d   = '0;
            end
        endcase

        // Abort wins over everything, including a done pulse due this cycle.
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            rep_d     = '0;
            bit_cnt_d = '0;
            x_d       = IDLE_BIT;
            x_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            pat_q     <= '0;
            rep_q     <= '0;
            bit_cnt_q <= '0;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            pat_q     <= pat_d;
            rep_q     <= rep_d;
            bit_cnt_q <= bit_cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x        = x_q;
    assign x_valid  = x_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rep_left = rep_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Testbench for seq_pattern_gen: two instances (GAP=0/IDLE_BIT=0 and
// GAP=2/IDLE_BIT=1) share stimulus; an arithmetic reference model predicts
// every output cycle, a vector table pins down the basic transfer, and
// hand-written sequences cover repeat_n=0, gaps, abort and async reset.
module tb_seq_pattern_gen;

    typedef struct packed {
        logic       x;
        logic       v;
        logic       b;
        logic       d;
        logic [3:0] rl;
    } out_t;

    typedef struct {
        logic       st;
        logic [3:0] p;
        logic [3:0] rn;
        logic       ab;
        out_t       exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] pattern;
    logic [3:0] repeat_n;

    logic       x0, v0, b0, d0;
    logic [3:0] rl0;
    logic       x1, v1, b1, d1;
    logic [3:0] rl1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state per instance.
    logic       m_act [2];
    int         m_k   [2];
    logic [3:0] m_pat [2];
    int         m_n   [2];
    int         m_gap [2];
    logic       m_idle[2];

    vec_t tbl [15];

    seq_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP(0), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .repeat_n(repeat_n), .abort(abort), .x(x0), .x_valid(v0),
        .busy(b0), .done(d0), .rep_left(rl0)
    );

    seq_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP(2), .IDLE_BIT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .repeat_n(repeat_n), .abort(abort), .x(x1), .x_valid(v1),
        .busy(b1), .done(d1), .rep_left(rl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs k cycles into a transfer, from the transfer's shape:
    // N repetitions of 4 bits, gap cycles between them, then one DONE cycle.
    function automatic out_t model_out(input logic act, input int gap,
                                       input logic idle_b, input logic [3:0] pat,
                                       input int n, input int k);
        out_t o;
        int   per, sendlen, j;
        o.x = idle_b; o.v = 1'b0; o.b = 1'b0; o.d = 1'b0; o.rl = 4'd0;
        if (act) begin
            o.b = 1'b1;
            sendlen = (n == 0) ? 0 : n * 4 + (n - 1) * gap;
            if (k > sendlen) begin
                o.d = 1'b1;
            end else begin
                j    = k - 1;
                per  = 4 + gap;
                o.rl = 4'(n - 1 - j / per);
                if ((j % per) < 4) begin
                    o.v = 1'b1;
                    o.x = pat[3 - (j % per)];
                end
            end
        end
        return o;
    endfunction

    task automatic model_step(input logic st, input logic ab,
                              input logic [3:0] p, input logic [3:0] rn);
        int len;
        for (int i = 0; i < 2; i++) begin
            len = (m_n[i] == 0) ? 1 : m_n[i] * 4 + (m_n[i] - 1) * m_gap[i] + 1;
            if (m_act[i]) begin
                if (ab) m_act[i] = 1'b0;
                else if (m_k[i] >= len) m_act[i] = 1'b0;
                else m_k[i] = m_k[i] + 1;
            end else if (st && !ab) begin
                m_act[i] = 1'b1;
                m_k[i]   = 1;
                m_pat[i] = p;
                m_n[i]   = int'(rn);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_k[i] = 0; m_pat[i] = 4'd0; m_n[i] = 0;
        end
    endtask

    task automatic cmp_out(input string name, input out_t got, input out_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got x=%b v=%b busy=%b done=%b rl=%0d, expected x=%b v=%b busy=%b done=%b rl=%0d",
                     name, $time, got.x, got.v, got.b, got.d, got.rl,
                     exp.x, exp.v, exp.b, exp.d, exp.rl);
        end
    endtask

    task automatic cmp_bit(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, got, exp);
        end
    endtask

    task automatic check_model();
        cmp_out("model_gap0", {x0, v0, b0, d0, rl0},
                model_out(m_act[0], m_gap[0], m_idle[0], m_pat[0], m_n[0], m_k[0]));
        cmp_out("model_gap2", {x1, v1, b1, d1, rl1},
                model_out(m_act[1], m_gap[1], m_idle[1], m_pat[1], m_n[1], m_k[1]));
    endtask

    // One clock: drive at negedge, update model at posedge, check at negedge.
    task automatic cyc(input logic st, input logic [3:0] p,
                       input logic [3:0] rn, input logic ab);
        start = st; pattern = p; repeat_n = rn; abort = ab;
        @(posedge clk);
        model_step(st, ab, p, rn);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    function automatic vec_t mk(input logic st, input logic [3:0] p,
                                input logic [3:0] rn, input logic ab,
                                input logic x, input logic v, input logic b,
                                input logic d, input logic [3:0] rl);
        vec_t t;
        t.st = st; t.p = p; t.rn = rn; t.ab = ab;
        t.exp.x = x; t.exp.v = v; t.exp.b = b; t.exp.d = d; t.exp.rl = rl;
        return t;
    endfunction

    initial begin
        // Row i: inputs during cycle i; expected dut0 outputs in cycle i+1.
        tbl[0]  = mk(1'b1, 4'b1101, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
        tbl[1]  = mk(1'b0, 4'b1101, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
        tbl[2]  = mk(1'b0, 4'b1101, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
        tbl[3]  = mk(1'b0, 4'b1101, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
        tbl[4]  = mk(1'b0, 4'b1101, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
        tbl[5]  = mk(1'b1, 4'b0000, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
        tbl[6]  = mk(1'b0, 4'b1101, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
        tbl[7]  = mk(1'b0, 4'b1101, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
        tbl[8]  = mk(1'b0, 4'b1101, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        tbl[9]  = mk(1'b0, 4'b1101, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        tbl[10] = mk(1'b0, 4'b1101, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tbl[11] = mk(1'b0, 4'b1101, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        tbl[12] = mk(1'b0, 4'b1101, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        tbl[13] = mk(1'b1, 4'b0000, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tbl[14] = mk(1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        m_gap[0] = 0; m_idle[0] = 1'b0;
        m_gap[1] = 2; m_idle[1] = 1'b1;
        model_reset();

        reset = 1'b0; start = 1'b0; abort = 1'b0;
        pattern = 4'd0; repeat_n = 4'd0;
        repeat (2) @(negedge clk);
        cmp_out("reset_gap0", {x0, v0, b0, d0, rl0}, 8'b0_0_0_0_0000);
        cmp_out("reset_gap2", {x1, v1, b1, d1, rl1}, 8'b1_0_0_0_0000);
        reset = 1'b1;
        @(negedge clk);

        // 1101 x3 back-to-back, with starts in mid-transfer and DONE ignored.
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].st, tbl[i].p, tbl[i].rn, tbl[i].ab);
            cmp_out("table", {x0, v0, b0, d0, rl0}, tbl[i].exp);
        end
        idle_cycles(6);

        // 0110 x2: gap instance shows two idle cycles and done at cycle 11.
        cyc(1'b1, 4'b0110, 4'd2, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) cyc(1'b0, 4'd0, 4'd0, 1'b0);
            cmp_bit("gap2_done", d1, c == 11);
            cmp_bit("gap2_valid", v1, (c <= 4) || (c >= 7 && c <= 10));
            cmp_bit("gap0_done", d0, c == 9);
        end
        idle_cycles(2);

        // repeat_n = 0: DONE right away, no bits.
        cyc(1'b1, 4'b1111, 4'd0, 1'b0);
        cmp_bit("rep0_done", d0, 1'b1);
        cmp_bit("rep0_busy", b0, 1'b1);
        cmp_bit("rep0_valid", v0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b0);
        cmp_bit("rep0_busy_after", b0, 1'b0);
        cmp_bit("rep0_done_after", d0, 1'b0);
        idle_cycles(2);

        // start together with abort in IDLE is ignored.
        cyc(1'b1, 4'b1010, 4'd2, 1'b1);
        cmp_bit("start_abort_busy", b0, 1'b0);
        idle_cycles(1);

        // Abort at cycle 6, restart at cycle 8.
        cyc(1'b1, 4'b1101, 4'd3, 1'b0);
        idle_cycles(5);
        cyc(1'b0, 4'd0, 4'd0, 1'b1);
        cmp_out("abort_c7", {x0, v0, b0, d0, rl0}, 8'b0_0_0_0_0000);
        cyc(1'b0, 4'd0, 4'd0, 1'b0);
        cyc(1'b1, 4'b1010, 4'd1, 1'b0);
        cmp_bit("restart_valid", v0, 1'b1);
        cmp_bit("restart_x", x0, 1'b1);
        idle_cycles(14);

        // Asynchronous reset between edges in the middle of SEND.
        cyc(1'b1, 4'b1011, 4'd5, 1'b0);
        idle_cycles(3);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        cmp_out("async_rst_gap0", {x0, v0, b0, d0, rl0}, 8'b0_0_0_0_0000);
        cmp_out("async_rst_gap2", {x1, v1, b1, d1, rl1}, 8'b1_0_0_0_0000);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 4'b1001, 4'd1, 1'b0);
        cmp_bit("post_rst_valid", v0, 1'b1);
        idle_cycles(8);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic       st, ab;
            logic [3:0] p, rn;
            st = ($urandom_range(0, 3) == 0);
            p  = 4'($urandom);
            rn = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            ab = ($urandom_range(0, 29) == 0);
            cyc(st, p, rn, ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
